// File: rtl/io_bus_controller_pkg.sv
// Shared types and constants for the IO bus controller: FSM states,
// register-map index helpers, status field positions and the timeout pattern.
package io_bus_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_IO,
        ST_DONE
    } state_t;

    // Read data returned when the memory side never answers
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Status word layout
    localparam int STATUS_ERR_BIT     = 0;
    localparam int STATUS_NUM_OUT_LSB = 8;
    localparam int STATUS_NUM_IN_LSB  = 16;

    // Register-map indices; the output registers start at index 0
    function automatic logic [7:0] idx_first_in(input int num_out);
        return 8'(num_out);
    endfunction

    function automatic logic [7:0] idx_counter(input int num_out, input int num_in);
        return 8'(num_out + num_in);
    endfunction

    function automatic logic [7:0] idx_status(input int num_out, input int num_in);
        return 8'(num_out + num_in + 1);
    endfunction

    function automatic logic [31:0] status_word(input logic err, input int num_out,
                                                input int num_in);
        logic [31:0] w;
        w = '0;
        w[STATUS_ERR_BIT]                      = err;
        w[STATUS_NUM_OUT_LSB +: 8]             = 8'(num_out);
        w[STATUS_NUM_IN_LSB +: 8]              = 8'(num_in);
        return w;
    endfunction

endpackage

// File: rtl/io_bus_controller_if.sv
// CPU data-port handshake: level requests from the CPU, completion flags and
// read data back from the controller.
interface io_bus_controller_if;

    logic        LeseDaten;
    logic        SchreibeDaten;
    logic [31:0] DatenAdresse;
    logic [31:0] DatenRaus;
    logic [31:0] DatenRein;
    logic        DatenGeladen;
    logic        DatenGespeichert;

    modport master (
        output LeseDaten, SchreibeDaten, DatenAdresse, DatenRaus,
        input  DatenRein, DatenGeladen, DatenGespeichert
    );

    modport slave (
        input  LeseDaten, SchreibeDaten, DatenAdresse, DatenRaus,
        output DatenRein, DatenGeladen, DatenGespeichert
    );

endinterface

// File: rtl/io_input_sync.sv
// Two-flop synchroniser for one asynchronous input channel.
module io_input_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift the raw input through two flops before anyone reads it
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking so meta->q forms two stages, not a wire.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_bus_controller.sv
// Decodes CPU data accesses: IO-select bit clear goes to memory with a
// timeout, set goes to the local register bank (outputs, synchronised inputs,
// cycle counter, status). Completion uses a four-phase handshake.
module io_bus_controller
    import io_bus_controller_pkg::*;
#(
    parameter int          NUM_OUT       = 2,
    parameter int          NUM_IN        = 2,
    parameter int          CH_WIDTH      = 8,
    parameter int          IO_SELECT_BIT = 31,
    parameter int          IO_WAIT       = 1,
    parameter int          MEM_TIMEOUT   = 255,
    parameter logic [31:0] OUT_RESET     = '0
) (
    input  logic                         Clock,
    input  logic                         Reset,
    io_bus_controller_if.slave           cpu,
    output logic                         MemLesen,
    output logic                         MemSchreiben,
    output logic [31:0]                  MemAdresse,
    output logic [31:0]                  MemSchreibDaten,
    input  logic [31:0]                  MemLesDaten,
    input  logic                         MemGelesen,
    input  logic                         MemGeschrieben,
    output logic [NUM_OUT*CH_WIDTH-1:0]  Ausgaenge,
    input  logic [NUM_IN*CH_WIDTH-1:0]   Eingaenge,
    output logic                         Fehler
);

    localparam logic [7:0]  IDX_IN    = idx_first_in(NUM_OUT);
    localparam logic [7:0]  IDX_CNT   = idx_counter(NUM_OUT, NUM_IN);
    localparam logic [7:0]  IDX_STAT  = idx_status(NUM_OUT, NUM_IN);
    localparam logic [31:0] WAIT_LAST = (IO_WAIT > 0) ? 32'(IO_WAIT - 1) : 32'd0;
    localparam logic [31:0] TMO_LAST  = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    state_t              state, state_next;
    logic                req, io_sel, start;
    logic                cap_write;
    logic [7:0]          cap_idx;
    logic [CH_WIDTH-1:0] cap_data;
    logic [31:0]         wait_cnt, tmo_cnt, counter;
    logic [CH_WIDTH-1:0] out_reg [NUM_OUT];
    logic [CH_WIDTH-1:0] sync_q  [NUM_IN];

    logic                mem_ok, mem_timeout, io_last, io_access, acc_write;
    logic [7:0]          acc_idx;
    logic [CH_WIDTH-1:0] acc_data;
    logic [31:0]         io_rd_data;
    logic                idx_valid, err_set, err_clr;

    // Input synchronisers, one per channel
    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        io_input_sync #(.WIDTH(CH_WIDTH)) u_sync (
            .clk (Clock),
            .rst (Reset),
            .d   (Eingaenge[k*CH_WIDTH +: CH_WIDTH]),
            .q   (sync_q[k])
        );
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign Ausgaenge[k*CH_WIDTH +: CH_WIDTH] = out_reg[k];
    end

    // Request decode; in IDLE the live bus is used so a zero-wait IO access
    // can complete on the capture edge
    always_comb begin
        req         = cpu.LeseDaten | cpu.SchreibeDaten;
        io_sel      = cpu.DatenAdresse[IO_SELECT_BIT];
        start       = (state == ST_IDLE) && req;
        acc_write   = (state == ST_IDLE) ? cpu.SchreibeDaten : cap_write;
        acc_idx     = (state == ST_IDLE) ? cpu.DatenAdresse[7:0] : cap_idx;
        acc_data    = (state == ST_IDLE) ? cpu.DatenRaus[CH_WIDTH-1:0] : cap_data;
        mem_ok      = cap_write ? MemGeschrieben : MemGelesen;
        mem_timeout = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
        io_last     = (IO_WAIT == 0) || (wait_cnt == WAIT_LAST);
        io_access   = (start && io_sel && (IO_WAIT == 0)) || ((state == ST_IO) && io_last);
    end

    // Register-map read mux and index validity
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        io_rd_data = '0;
        idx_valid  = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (acc_idx == 8'(k)) begin
                io_rd_data = 32'(out_reg[k]);
                idx_valid  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (acc_idx == IDX_IN + 8'(k)) begin
                io_rd_data = 32'(sync_q[k]);
                idx_valid  = 1'b1;
            end
        end
        if (acc_idx == IDX_CNT) begin
            io_rd_data = counter;
            idx_valid  = 1'b1;
        end
        if (acc_idx == IDX_STAT) begin
            io_rd_data = status_word(Fehler, NUM_OUT, NUM_IN);
            idx_valid  = 1'b1;
        end
    end

    // Error sources and the status-write clear
    always_comb begin
        err_set = (start && cpu.LeseDaten && cpu.SchreibeDaten)
                || (io_access && !idx_valid)
                || ((state == ST_MEM) && !mem_ok && mem_timeout);
        err_clr = io_access && acc_write && (acc_idx == IDX_STAT);
    end

    // FSM next-state
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (req) state_next = !io_sel ? ST_MEM
                                         : ((IO_WAIT == 0) ? ST_DONE : ST_IO);
            ST_MEM:  if (mem_ok || mem_timeout) state_next = ST_DONE;
            ST_IO:   if (io_last) state_next = ST_DONE;
            ST_DONE: if (!req) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Capture, memory strobes, wait/timeout counters and CPU completion
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cap_write            <= 1'b0;
            cap_idx              <= '0;
            cap_data             <= '0;
            wait_cnt             <= '0;
            tmo_cnt              <= '0;
            MemLesen             <= 1'b0;
            MemSchreiben         <= 1'b0;
            MemAdresse           <= '0;
            MemSchreibDaten      <= '0;
            cpu.DatenRein        <= '0;
            cpu.DatenGeladen     <= 1'b0;
            cpu.DatenGespeichert <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    cap_write <= cpu.SchreibeDaten;
                    cap_idx   <= cpu.DatenAdresse[7:0];
                    cap_data  <= cpu.DatenRaus[CH_WIDTH-1:0];
                    wait_cnt  <= '0;
                    tmo_cnt   <= '0;
                    if (!io_sel) begin
                        MemAdresse      <= cpu.DatenAdresse;
                        MemSchreibDaten <= cpu.DatenRaus;
                        MemLesen        <= !cpu.SchreibeDaten;
                        MemSchreiben    <= cpu.SchreibeDaten;
                    end
                end
                ST_MEM: begin
                    if (mem_ok || mem_timeout) begin
                        MemLesen     <= 1'b0;
                        MemSchreiben <= 1'b0;
                        if (!cap_write) cpu.DatenRein <= mem_ok ? MemLesDaten : TIMEOUT_DATA;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                ST_IO: if (!io_last) wait_cnt <= wait_cnt + 32'd1;
                ST_DONE: if (!req) begin
                    cpu.DatenGeladen     <= 1'b0;
                    cpu.DatenGespeichert <= 1'b0;
                end
                default: ;
            endcase
            if (io_access && !acc_write) cpu.DatenRein <= io_rd_data;
            if ((state != ST_DONE) && (state_next == ST_DONE)) begin
                cpu.DatenGeladen     <= !acc_write;
                cpu.DatenGespeichert <= acc_write;
            end
        end
    end

    // Register bank writes, free-running counter and sticky error
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: the output bank is a handful of flops, so every entry is reset.
            for (int k = 0; k < NUM_OUT; k++) out_reg[k] <= OUT_RESET[CH_WIDTH-1:0];
            counter <= '0;
            Fehler  <= 1'b0;
        end else begin
            if (io_access && acc_write && (acc_idx == IDX_CNT)) counter <= '0;
            else                                                counter <= counter + 32'd1;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (io_access && acc_write && (acc_idx == 8'(k))) out_reg[k] <= acc_data;
            end
            if (err_set)      Fehler <= 1'b1;
            else if (err_clr) Fehler <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed self-checking bench for io_bus_controller (IO_WAIT=1, MEM_TIMEOUT=8).
module tb_io_bus_controller;
    import io_bus_controller_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        MemLesen, MemSchreiben;
    logic [31:0] MemAdresse, MemSchreibDaten;
    logic [31:0] MemLesDaten = '0;
    logic        MemGelesen = 1'b0;
    logic        MemGeschrieben = 1'b0;
    logic [15:0] Ausgaenge;
    logic [15:0] Eingaenge = '0;
    logic        Fehler;

    int checks = 0;
    int errors = 0;

    io_bus_controller_if bus ();

    io_bus_controller #(
        .NUM_OUT(2), .NUM_IN(2), .CH_WIDTH(8), .IO_SELECT_BIT(31),
        .IO_WAIT(1), .MEM_TIMEOUT(8), .OUT_RESET(32'd0)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .cpu             (bus.slave),
        .MemLesen        (MemLesen),
        .MemSchreiben    (MemSchreiben),
        .MemAdresse      (MemAdresse),
        .MemSchreibDaten (MemSchreibDaten),
        .MemLesDaten     (MemLesDaten),
        .MemGelesen      (MemGelesen),
        .MemGeschrieben  (MemGeschrieben),
        .Ausgaenge       (Ausgaenge),
        .Eingaenge       (Eingaenge),
        .Fehler          (Fehler)
    );

    always #5 Clock = ~Clock;

    // Present a request on a falling edge and wait (bounded) for a done flag;
    // lat counts rising edges from the request to the flag being visible.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output int lat);
        @(negedge Clock);
        bus.SchreibeDaten = wr;
        bus.LeseDaten     = rd;
        bus.DatenAdresse  = addr;
        bus.DatenRaus     = wdata;
        lat = 0;
        do begin
            @(posedge Clock); #1;
            lat++;
        end while (!(bus.DatenGeladen || bus.DatenGespeichert) && lat < 50);
        checks++;
        if (!(bus.DatenGeladen || bus.DatenGespeichert)) begin
            errors++;
            $display("FAIL access_done addr=%h: no done flag within %0d cycles", addr, lat);
        end
        rdata = bus.DatenRein;
    endtask

    task automatic release_req();
        @(negedge Clock);
        bus.LeseDaten     = 1'b0;
        bus.SchreibeDaten = 1'b0;
        @(posedge Clock); #1;
    endtask

    // Memory model: answers a read on the 4th strobe cycle when asked to,
    // and counts how many cycles MemLesen stayed high.
    task automatic mem_responder(input bit answer, input logic [31:0] data, output int hi_cnt);
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clock); #1;
            if (MemLesen) begin
                hi_cnt++;
                if (answer && hi_cnt == 4) begin
                    MemGelesen  = 1'b1;
                    MemLesDaten = data;
                end
            end else begin
                MemGelesen = 1'b0;
                if (hi_cnt > 0) break;
            end
        end
        MemGelesen = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          lat;
        bus.LeseDaten = 1'b0; bus.SchreibeDaten = 1'b0;
        bus.DatenAdresse = '0; bus.DatenRaus = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock) Reset = 1'b0;
        checks++; if (Ausgaenge !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", Ausgaenge); end
        checks++; if (Fehler !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", Fehler); end
        checks++; if ({bus.DatenGeladen, bus.DatenGespeichert, MemLesen, MemSchreiben} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000",
                               {bus.DatenGeladen, bus.DatenGespeichert, MemLesen, MemSchreiben}); end
        checks++; if (bus.DatenRein !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.DatenRein); end
        // Counter is 0 after the last reset edge; capture on the 5th edge after
        // release, access on the 6th returns the pre-edge value 5.
        repeat (3) @(negedge Clock);
        do_access(1'b0, 1'b1, 32'h8000_0004, 32'h0, rd, lat);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL counter_read got=%0d exp=5", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL io_read_latency got=%0d exp=2", lat); end
        release_req();
    endtask

    task automatic test_out_write();
        logic [31:0] rd;
        int          lat;
        do_access(1'b1, 1'b0, 32'h8000_0001, 32'h0000_00A5, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got=%0d exp=2", lat); end
        checks++; if (bus.DatenGeladen !== 1'b0) begin errors++; $display("FAIL write_rd_flag got=%b exp=0", bus.DatenGeladen); end
        @(posedge Clock); #1;
        checks++; if (bus.DatenGespeichert !== 1'b1) begin errors++; $display("FAIL write_flag_held got=%b exp=1", bus.DatenGespeichert); end
        checks++; if (Ausgaenge !== 16'hA500) begin errors++; $display("FAIL out_ch1 got=%h exp=A500", Ausgaenge); end
        release_req();
        checks++; if (bus.DatenGespeichert !== 1'b0) begin errors++; $display("FAIL write_flag_drop got=%b exp=0", bus.DatenGespeichert); end
        do_access(1'b0, 1'b1, 32'h8000_0001, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL out_readback got=%h exp=000000A5", rd); end
        release_req();
        checks++; if (bus.DatenGeladen !== 1'b0) begin errors++; $display("FAIL read_flag_drop got=%b exp=0", bus.DatenGeladen); end
    endtask

    task automatic test_mem_read();
        logic [31:0] rd;
        int          lat, hi;
        fork
            do_access(1'b0, 1'b1, 32'h0000_0010, 32'h0, rd, lat);
            mem_responder(1'b1, 32'h1234_5678, hi);
        join
        checks++; if (hi !== 4) begin errors++; $display("FAIL mem_strobe_len got=%0d exp=4", hi); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL mem_rdata got=%h exp=12345678", rd); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL mem_latency got=%0d exp=5", lat); end
        checks++; if (MemAdresse !== 32'h0000_0010) begin errors++; $display("FAIL mem_addr got=%h exp=00000010", MemAdresse); end
        release_req();
    endtask

    task automatic test_mem_timeout();
        logic [31:0] rd;
        int          lat, hi;
        fork
            do_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, rd, lat);
            mem_responder(1'b0, 32'h0, hi);
        join
        checks++; if (hi !== 8) begin errors++; $display("FAIL tmo_strobe_len got=%0d exp=8", hi); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_rdata got=%h exp=DEADBEEF", rd); end
        checks++; if (Fehler !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", Fehler); end
        release_req();
        do_access(1'b1, 1'b0, 32'h8000_0005, 32'h0, rd, lat);
        release_req();
        checks++; if (Fehler !== 1'b0) begin errors++; $display("FAIL status_clear got=%b exp=0", Fehler); end
        do_access(1'b0, 1'b1, 32'h8000_0005, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0002_0200) begin errors++; $display("FAIL status_word got=%h exp=00020200", rd); end
        release_req();
    endtask

    task automatic test_input_sync();
        logic [31:0] rd;
        int          lat;
        // Change and request together: access lands on the 2nd edge, old value
        Eingaenge = 16'hC300;
        do_access(1'b0, 1'b1, 32'h8000_0003, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_0000) begin errors++; $display("FAIL sync_early got=%h exp=00000000", rd); end
        release_req();
        // One edge later: access lands on the 3rd edge after the change
        Eingaenge = 16'h3C00;
        @(negedge Clock);
        do_access(1'b0, 1'b1, 32'h8000_0003, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL sync_third got=%h exp=0000003C", rd); end
        release_req();
        // Writes to an input index are ignored without error
        do_access(1'b1, 1'b0, 32'h8000_0003, 32'hFF, rd, lat);
        release_req();
        checks++; if (Fehler !== 1'b0) begin errors++; $display("FAIL in_write_err got=%b exp=0", Fehler); end
    endtask

    task automatic test_both_requests();
        logic [31:0] rd;
        int          lat;
        do_access(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0055, rd, lat);
        checks++; if ({bus.DatenGespeichert, bus.DatenGeladen} !== 2'b10) begin
            errors++; $display("FAIL both_flags got=%b exp=10", {bus.DatenGespeichert, bus.DatenGeladen}); end
        checks++; if (Ausgaenge !== 16'hA555) begin errors++; $display("FAIL both_out got=%h exp=A555", Ausgaenge); end
        checks++; if (Fehler !== 1'b1) begin errors++; $display("FAIL both_err got=%b exp=1", Fehler); end
        release_req();
        do_access(1'b1, 1'b0, 32'h8000_0005, 32'h0, rd, lat);
        release_req();
    endtask

    task automatic test_counter_clear();
        logic [31:0] rd;
        int          lat;
        // Cleared at the access edge, then two more edges before the next
        // access edge samples it
        do_access(1'b1, 1'b0, 32'h8000_0004, 32'h0, rd, lat);
        release_req();
        do_access(1'b0, 1'b1, 32'h8000_0004, 32'h0, rd, lat);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL counter_clear got=%0d exp=2", rd); end
        release_req();
    endtask

    task automatic test_reset_in_mem();
        logic [31:0] rd;
        int          lat;
        @(negedge Clock);
        bus.LeseDaten    = 1'b1;
        bus.DatenAdresse = 32'h0000_0020;
        repeat (3) @(posedge Clock);
        #1;
        checks++; if (MemLesen !== 1'b1) begin errors++; $display("FAIL mem_wait_strobe got=%b exp=1", MemLesen); end
        @(negedge Clock);
        Reset = 1'b1;
        bus.LeseDaten = 1'b0;
        @(posedge Clock); #1;
        checks++; if (MemLesen !== 1'b0) begin errors++; $display("FAIL abort_strobe got=%b exp=0", MemLesen); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        checks++; if (bus.DatenGeladen !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.DatenGeladen); end
        checks++; if (Ausgaenge !== 16'h0000) begin errors++; $display("FAIL abort_out got=%h exp=0000", Ausgaenge); end
        @(negedge Clock) Reset = 1'b0;
        do_access(1'b0, 1'b1, 32'h8000_007F, 32'h0, rd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bad_idx_rdata got=%h exp=0", rd); end
        checks++; if (Fehler !== 1'b1) begin errors++; $display("FAIL bad_idx_err got=%b exp=1", Fehler); end
        release_req();
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_mem_read();
        test_mem_timeout();
        test_input_sync();
        test_both_requests();
        test_counter_clear();
        test_reset_in_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bus_controller.md
Name: io_bus_controller

Overview:
- Sits between the CPU data port and the data cache.
- Decodes every CPU data access. Accesses with the IO select bit clear are forwarded to the memory side; accesses with it set go to a local bank of memory-mapped registers.
- The local bank holds parametrised output registers, synchronised input ports, a cycle counter and a status word.
- Generalises the single address-decoded LED register to N channels. Adds readback, IO wait states, a memory timeout and a four-phase completion handshake.

Parameters:
NUM_OUT, 2, number of R/W output registers
NUM_IN, 2, number of read-only input ports
CH_WIDTH, 8, width of each output/input channel (1..32)
IO_SELECT_BIT, 31, address bit that selects the IO region
IO_WAIT, 1, extra wait cycles for an IO access (0 allowed)
MEM_TIMEOUT, 255, max cycles waiting for memory completion (0 = no timeout)
OUT_RESET, 0, reset value of every output register

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
LeseDaten  in  1  CPU read request (level, held until done)
SchreibeDaten  in  1  CPU write request (level, held until done)
DatenAdresse  in  32  CPU word address
DatenRaus  in  32  CPU write data
DatenRein  out  32  read data to CPU
DatenGeladen  out  1  read complete
DatenGespeichert  out  1  write complete
MemLesen  out  1  memory read strobe
MemSchreiben  out  1  memory write strobe
MemAdresse  out  32  captured address
MemSchreibDaten  out  32  captured write data
MemLesDaten  in  32  memory read data
MemGelesen  in  1  memory read done
MemGeschrieben  in  1  memory write done
Ausgaenge  out  NUM_OUT*CH_WIDTH  output channels; channel k = bits [k*CH_WIDTH +: CH_WIDTH]
Eingaenge  in  NUM_IN*CH_WIDTH  asynchronous input channels
Fehler  out  1  sticky bus error

Behaviour:
- One clock domain, Clock. Reset is synchronous and active-high, named Reset.
- Reset values:
  - state IDLE; all strobes and done flags 0
  - DatenRein 0; Mem* outputs 0
  - output registers OUT_RESET; counter 0; Fehler 0; sync flops 0
- A reset in any state aborts the access and applies the reset values at that edge; no completion is signalled.
- IDLE:
  - If SchreibeDaten=1, capture address and data, then go to MEM or IO according to DatenAdresse[IO_SELECT_BIT]. Write wins over read.
  - If both requests are 1, perform the write and set Fehler.
  - If only LeseDaten=1, capture address and route the same way.
- MEM:
  - MemLesen or MemSchreiben is registered high from the first MEM cycle and held until MemGelesen / MemGeschrieben is sampled high.
  - On that cycle: drop the strobe, latch MemLesDaten into DatenRein (reads only), go to DONE.
  - A timeout counter starts at 0 on entry. If it reaches MEM_TIMEOUT without completion: drop the strobe, DatenRein=0xDEADBEEF for reads, set Fehler, go to DONE.
- IO:
  - Wait IO_WAIT cycles, then perform the register access and go to DONE.
  - With IO_WAIT=0, IDLE goes directly to DONE, and the access happens on the capture edge.
  - Minimum latency from request to done: 1 cycle for IO_WAIT=0, IO_WAIT+1 otherwise.
- DONE:
  - DatenGeladen=1 for a read, or DatenGespeichert=1 for a write. DatenRein is stable.
  - Stay in DONE while the captured request stays 1. Return to IDLE on the first cycle both requests are 0, with done flags 0 at that edge.
  - No new access starts before that IDLE cycle (four-phase handshake).
- IO register map, index = captured address bits [7:0]:
  - 0..NUM_OUT-1: output registers, R/W. Write stores DatenRaus[CH_WIDTH-1:0]; read returns them zero-extended.
  - NUM_OUT..NUM_OUT+NUM_IN-1: inputs via two-flop synchroniser, read-only. Writes are ignored without error.
  - NUM_OUT+NUM_IN: counter. Free-running 32-bit, +1 every cycle, wraps 0xFFFFFFFF to 0. A write clears it to 0, and the clear wins over the increment on that edge.
  - NUM_OUT+NUM_IN+1: status, read-only. Bit 0 = Fehler, [15:8] = NUM_OUT, [23:16] = NUM_IN. Writing any value clears Fehler.
  - Other indices: read 0, write ignored, access still completes, Fehler set.
- Fehler set and clear in the same cycle: set wins.

Decomposition:
- Shared package:
  - state enum (IDLE, MEM, IO, DONE)
  - register index offsets as localparams derived from NUM_OUT/NUM_IN
  - timeout read pattern 0xDEADBEEF
  - status field positions
- One sub-module, io_input_sync: a CH_WIDTH two-flop synchroniser instantiated per input channel.
- FSM, register bank and counter stay in the top module.

Test Plan:
- Reset held 3 cycles, then release -> Ausgaenge=0, counter reads 5 at the first possible read after release with IO_WAIT=1, Fehler=0, all done flags 0.
- Write 0x000000A5 to address 0x80000001 -> DatenGespeichert=1 after 2 cycles, held until SchreibeDaten drops; Ausgaenge[15:8]=0xA5; readback of 0x80000001 = 0x000000A5.
- Read 0x00000010 with memory model answering MemGelesen after 4 cycles, data 0x12345678 -> MemLesen high exactly 4 cycles, DatenRein=0x12345678, DatenGeladen=1 one cycle later.
- Memory never answers, MEM_TIMEOUT=8 -> MemLesen drops after 8 cycles, DatenRein=0xDEADBEEF, Fehler=1; write to status index 5 -> Fehler=0.
- Eingaenge channel 1 = 0x3C -> read index 3 returns 0x3C only from the third cycle after the change; both LeseDaten and SchreibeDaten high -> write performed, Fehler=1.
- Reset asserted during MEM wait -> MemLesen=0 and state IDLE at the next edge; a subsequent read of index 0x7F returns 0 and sets Fehler.
